// File: rtl/pipo_write_arbiter_if.sv
// Request/acknowledge bundle between NUM_REQ writers and the shared PIPO register arbiter.
// The lock vector exists only when PIPO_ARB_LOCK_EN is defined.
interface pipo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         q;
    logic [IDW-1:0]           owner;
    logic                     busy;
`ifdef PIPO_ARB_LOCK_EN
    logic [NUM_REQ-1:0]       lock;

    modport master (
        output req, wdata, lock,
        input  ack, q, owner, busy
    );

    modport slave (
        input  req, wdata, lock,
        output ack, q, owner, busy
    );
`else
    modport master (
        output req, wdata,
        input  ack, q, owner, busy
    );

    modport slave (
        input  req, wdata,
        output ack, q, owner, busy
    );
`endif
endinterface

// File: rtl/pipo_write_arbiter.sv
// Round-robin req/ack arbiter in front of one shared WIDTH-bit PIPO holding register.
// Optional exclusive-ownership lock is enabled with the PIPO_ARB_LOCK_EN macro.
module pipo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipo_write_arbiter_if.slave  bus
);
    localparam int NPAD = 1 << IDW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   lock_vec;
    logic [NPAD-1:0]      lock_pad;
    logic                 lock_active;
    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [IDW-1:0]       win;

    function automatic logic [NPAD-1:0] pad_vec(input logic [NUM_REQ-1:0] v);
        logic [NPAD-1:0] t;
        t = '0;
        t[NUM_REQ-1:0] = v;
        return t;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NPAD-1:0] t;
        t = '0;
        t[idx] = 1'b1;
        return t[NUM_REQ-1:0];
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        logic [IDW:0] s;
        s = {1'b0, idx} + (IDW+1)'(1);
        if (s >= (IDW+1)'(NUM_REQ)) begin
            s = '0;
        end
        return s[IDW-1:0];
    endfunction

`ifdef PIPO_ARB_LOCK_EN
    assign lock_vec = bus.lock;
`else
    assign lock_vec = '0;
`endif

    assign lock_pad    = pad_vec(lock_vec);
    // The owner keeps exclusivity from its ack cycle onward while it holds lock.
    assign lock_active = (state_q != IDLE) && lock_pad[owner_q];

    always_comb begin
        eligible = bus.req & ~ack_q;
        if (lock_active) begin
            eligible = eligible & onehot(owner_q);
        end
    end

    // Rotating search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [NPAD-1:0] elig_pad;
        logic [IDW:0]    cand;
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        elig_pad = pad_vec(eligible);
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!found && elig_pad[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (found) begin
            ack_d   = onehot(win);
            owner_d = win;
            ptr_d   = next_idx(win);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDW'(i) == win) begin
                    q_d = bus.wdata[i*WIDTH +: WIDTH];
                end
            end
        end
        busy_d = |ack_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = lock_pad[win] ? LOCKED : GRANT;
                end
            end
            GRANT, LOCKED: begin
                if (lock_active) begin
                    state_d = LOCKED;
                end else if (found) begin
                    state_d = lock_pad[win] ? LOCKED : GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.q     = q_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Directed vector bench for pipo_write_arbiter (NUM_REQ=4, WIDTH=8, IDW=2).
module tb_pipo_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipo_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .IDW(2)) bus ();

    pipo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] WA = 32'hAAAA_AAAA;
    localparam logic [31:0] W1 = 32'hAAAA_AA11;
    localparam logic [31:0] WR = 32'h8866_4422;

    function automatic void add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                                input logic [3:0] a, input logic [7:0] qq,
                                input logic [1:0] o, input logic b);
        vec_t v;
        v.rst_n = r; v.req = rq; v.wdata = wd;
        v.ack = a; v.q = qq; v.owner = o; v.busy = b;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] a, input logic [7:0] qq,
                             input logic [1:0] o, input logic b);
        chk({tag, " ack"},   32'(bus.ack),   32'(a));
        chk({tag, " q"},     32'(bus.q),     32'(qq));
        chk({tag, " owner"}, 32'(bus.owner), 32'(o));
        chk({tag, " busy"},  32'(bus.busy),  32'(b));
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
        @(negedge clk);
        rst_n     = r;
        bus.req   = rq;
        bus.wdata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;
`ifdef PIPO_ARB_LOCK_EN
        bus.lock  = '0;
`endif

        // reset, idle
        add(0, 4'b0000, WA, 4'b0000, 8'h00, 2'd0, 0);
        add(0, 4'b0000, WA, 4'b0000, 8'h00, 2'd0, 0);
        add(1, 4'b0000, WA, 4'b0000, 8'h00, 2'd0, 0);
        add(1, 4'b0000, WA, 4'b0000, 8'h00, 2'd0, 0);
        add(1, 4'b0000, WA, 4'b0000, 8'h00, 2'd0, 0);
        // single write, req dropped on ack
        add(1, 4'b0001, W1, 4'b0001, 8'h11, 2'd0, 1);
        add(1, 4'b0000, WA, 4'b0000, 8'h11, 2'd0, 0);
        add(1, 4'b0000, WA, 4'b0000, 8'h11, 2'd0, 0);
        // reset again so rotation starts at 0
        add(0, 4'b0000, WR, 4'b0000, 8'h00, 2'd0, 0);
        add(1, 4'b1111, WR, 4'b0001, 8'h22, 2'd0, 1);
        add(1, 4'b1111, WR, 4'b0010, 8'h44, 2'd1, 1);
        add(1, 4'b1111, WR, 4'b0100, 8'h66, 2'd2, 1);
        add(1, 4'b1111, WR, 4'b1000, 8'h88, 2'd3, 1);
        add(1, 4'b1111, WR, 4'b0001, 8'h22, 2'd0, 1);
        add(1, 4'b1111, WR, 4'b0010, 8'h44, 2'd1, 1);
        add(1, 4'b1111, WR, 4'b0100, 8'h66, 2'd2, 1);
        // ptr=3: search 3 then wraps to 0 ahead of 2
        add(1, 4'b0000, WR, 4'b0000, 8'h66, 2'd2, 0);
        add(1, 4'b0101, WR, 4'b0001, 8'h22, 2'd0, 1);
        add(1, 4'b0101, WR, 4'b0100, 8'h66, 2'd2, 1);
        // single requester held high: alternate-cycle acks
        add(1, 4'b0001, WR, 4'b0001, 8'h22, 2'd0, 1);
        add(1, 4'b0001, WR, 4'b0000, 8'h22, 2'd0, 0);
        add(1, 4'b0001, WR, 4'b0001, 8'h22, 2'd0, 1);
        add(1, 4'b0001, WR, 4'b0000, 8'h22, 2'd0, 0);

        foreach (tv[k]) begin
            step(tv[k].rst_n, tv[k].req, tv[k].wdata);
            check_out($sformatf("vec%0d", k), tv[k].ack, tv[k].q, tv[k].owner, tv[k].busy);
        end

        // asynchronous reset while ack=0100
        step(0, 4'b0000, WR);
        step(1, 4'b0100, WR);
        check_out("t5_pre", 4'b0100, 8'h66, 2'd2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t5_async", 4'b0000, 8'h00, 2'd0, 0);
        step(0, 4'b0000, WR);
        step(1, 4'b1000, WR);
        check_out("t5_rel", 4'b1000, 8'h88, 2'd3, 1);

        // ptr must return to 0: after owner 2 (ptr=3) and reset, 1010 grants 1
        step(1, 4'b0000, WR);
        step(1, 4'b0100, WR);
        check_out("t5_own2", 4'b0100, 8'h66, 2'd2, 1);
        #2;
        rst_n = 1'b0;
        step(0, 4'b0000, WR);
        step(1, 4'b1010, WR);
        check_out("t5_ptr0", 4'b0010, 8'h44, 2'd1, 1);

`ifdef PIPO_ARB_LOCK_EN
        step(0, 4'b0000, WA);
        bus.lock = 4'b0001;
        step(1, 4'b0011, 32'hAAAA_7733);
        check_out("t6_l0", 4'b0001, 8'h33, 2'd0, 1);
        step(1, 4'b0011, 32'hAAAA_7733);
        check_out("t6_l1", 4'b0000, 8'h33, 2'd0, 0);
        step(1, 4'b0011, 32'hAAAA_7733);
        check_out("t6_l2", 4'b0001, 8'h33, 2'd0, 1);
        step(1, 4'b0011, 32'hAAAA_7733);
        check_out("t6_l3", 4'b0000, 8'h33, 2'd0, 0);
        bus.lock = 4'b0000;
        step(1, 4'b0011, 32'hAAAA_7733);
        check_out("t6_rel", 4'b0010, 8'h77, 2'd1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipo_write_arbiter.md
Name: pipo_write_arbiter

Overview:
Round-robin write arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register among NUM_REQ requesters. Each cycle it selects at most one requester, loads that requester's data into the register and returns a registered one-hot acknowledge. It sits in front of the sequential register datapath, replacing the single shared enable/data pair with a per-requester req/ack handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, register data width in bits
IDW, 2, owner-index width; must satisfy 2**IDW >= NUM_REQ

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester write request; held high until the matching ack is seen
wdata  input  NUM_REQ*WIDTH  flat data bus; requester i uses bits [i*WIDTH +: WIDTH]
ack  output  NUM_REQ  registered one-hot write acknowledge, one-cycle pulse
q  output  WIDTH  shared register contents
owner  output  IDW  index of the last requester written
busy  output  1  high in the cycle after any write; equals |ack
lock  input  NUM_REQ  per-requester ownership lock; present only with PIPO_ARB_LOCK_EN

Behaviour:
- Reset (rst_n low, asynchronous): q=0, ack=0, owner=0, busy=0, round-robin pointer ptr=0, state=IDLE. All outputs hold these values while rst_n is low.
- Eligible set: eligible = req & ~ack. A requester whose ack is high this cycle is masked, so one request produces one write.
- Arbitration: the winner w is the first set bit of eligible, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- At a posedge with eligible != 0:
  - q <= wdata[w]
  - ack <= one-hot(w)
  - owner <= w
  - ptr <= (w+1) mod NUM_REQ; this includes the wrap from NUM_REQ-1 to 0.
- At a posedge with eligible == 0: q, owner and ptr hold; ack <= 0.
- Latency: a request sampled at edge k is written at edge k, and ack and the new q are visible together after edge k. A requester should drop req during its ack cycle. If req stays high, it re-enters arbitration the following cycle.
- Fairness: with all requesters continuously re-requesting, grants rotate 0,1,2,3,0,... A requester waits at most NUM_REQ-1 writes.
- Single requester continuously high: written every second cycle, because of the ack mask.
- Reset mid-operation: a pending ack is cleared at once and ptr returns to 0. Requests are re-arbitrated from index 0 after rst_n deasserts.
- State machine (meaningful with the lock feature; without it the block stays in IDLE/GRANT only):
  - IDLE: go to GRANT on a write.
  - GRANT: the ack cycle. Go to LOCKED if the feature is enabled and lock[owner] is high; otherwise follow the IDLE rule.
  - LOCKED: only requester owner is eligible (the ack mask still applies). Go to IDLE the cycle lock[owner] is low.

Optional Feature:
PIPO_ARB_LOCK_EN
- Defined:
  - The lock port exists.
  - A winner asserting lock[w] at its write edge, or during its ack cycle, retains exclusive ownership. Other requesters are blocked while state=LOCKED.
  - ptr is not advanced by locked writes beyond the normal w+1 update.
  - On lock release, arbitration resumes from ptr.
- Undefined: no lock port, LOCKED state is unreachable, and pure round-robin applies.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then req=0 → q=00, ack=0, owner=0, busy=0 for 3 cycles.
2. Single write: req=0001, wdata0=8'h11, req dropped on ack → ack=0001 for exactly 1 cycle, q=11, owner=0; q still 11 with req=0 and other wdata=AA.
3. Round-robin: req=1111 held, wdata[i]=8'h22*(i+1) → successive writes q=22,44,66,88,22; ack rotates 0001,0010,0100,1000; busy high on each ack cycle.
4. Wrap and mask: ptr=3 after owner 2, req=0101 → requester 0 wins (wrap) then 2; a continuously held req=0001 alone yields ack on alternate cycles only.
5. Async reset mid-ack: assert rst_n=0 between edges while ack=0100 → ack, q and owner go to 0 immediately with no clock edge; after release with req=1000, the first grant goes to 3, searched from ptr=0.
6. (PIPO_ARB_LOCK_EN) req=0011, lock=0001, wdata0=33, wdata1=77 → requester 0 writes 33 repeatedly on alternate cycles while requester 1 gets no ack; drop lock → requester 1 writes 77 next.
